// File: rtl/buzzer_request_arbiter.sv
// Buzzer request arbiter: shares one buzzer core among NUM_REQ requesters.
// Grants one request at a time, counts beeps, reports completion/abort.
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   req_valid/req_ready per-requester request and one-cycle accept strobe
//   req_mode/on/off/count  per-requester buzzer parameters (flattened)
//   abort               terminates the active request
//   done/done_aborted   one-cycle completion strobe and its qualifier
//   busy, grant_id      arbiter status, current/last owner
//   buzzer_active       on-phase indicator from the buzzer core
//   bz_*                latched control and parameters to the buzzer core
//
// Build option: define BUZZER_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest valid index wins.
module buzzer_request_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 8,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_mode,
  input  logic [32*NUM_REQ-1:0]    req_on,
  input  logic [32*NUM_REQ-1:0]    req_off,
  input  logic [CNT_W*NUM_REQ-1:0] req_count,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       done,
  output logic                     done_aborted,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  input  logic                     buzzer_active,
  output logic                     bz_resetn,
  output logic                     bz_enable,
  output logic [1:0]               bz_mode,
  output logic [31:0]              bz_duration_on,
  output logic [31:0]              bz_duration_off
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] done_q;
  logic               done_aborted_q;
  logic               busy_q;
  logic [IDW-1:0]     grant_id_q;
  logic               bz_resetn_q;
  logic               bz_enable_q;
  logic [1:0]         bz_mode_q;
  logic [31:0]        bz_on_q;
  logic [31:0]        bz_off_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               act_prev_q;

  logic [IDW-1:0]     win_d;
  logic [1:0]         mode_d;
  logic [31:0]        on_d;
  logic [31:0]        off_d;
  logic [CNT_W-1:0]   cnt_sel_d;
  logic [CNT_W-1:0]   tgt_d;
  logic               beep_fall;
  logic               last_beep;

`ifdef BUZZER_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    logic [IDW:0] sum;
    logic         found;
    win_d = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        win_d = sum[IDW-1:0];
      end
    end
  end

  assign ptr_d = (win_d == IDW'(NUM_REQ-1)) ?
                 '0 : win_d + 1'b1;
`else
  always_comb begin
    win_d = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i])
        win_d = IDW'(i);
    end
  end
`endif

  always_comb begin
    mode_d    = '0;
    on_d      = '0;
    off_d     = '0;
    cnt_sel_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IDW'(i)) begin
        mode_d    = req_mode[2*i +: 2];
        on_d      = req_on[32*i +: 32];
        off_d     = req_off[32*i +: 32];
        cnt_sel_d = req_count[CNT_W*i +: CNT_W];
      end
    end
    // A zero count still produces one beep.
    tgt_d = (cnt_sel_d == '0) ? CNT_W'(1) : cnt_sel_d;
  end

  assign beep_fall = act_prev_q & ~buzzer_active;
  assign last_beep = (cnt_q + 1'b1) == tgt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      req_ready_q    <= '0;
      done_q         <= '0;
      done_aborted_q <= 1'b0;
      busy_q         <= 1'b0;
      grant_id_q     <= '0;
      bz_resetn_q    <= 1'b0;
      bz_enable_q    <= 1'b0;
      bz_mode_q      <= '0;
      bz_on_q        <= '0;
      bz_off_q       <= '0;
      tgt_q          <= '0;
      cnt_q          <= '0;
      act_prev_q     <= 1'b0;
`ifdef BUZZER_ARB_ROUND_ROBIN_EN
      ptr_q          <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      done_q      <= '0;
      act_prev_q  <= buzzer_active;
      unique case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            state_q     <= S_LOAD;
            busy_q      <= 1'b1;
            grant_id_q  <= win_d;
            req_ready_q <= NUM_REQ'(1) << win_d;
            bz_resetn_q <= 1'b1;
            bz_enable_q <= 1'b0;
            bz_mode_q   <= mode_d;
            bz_on_q     <= on_d;
            bz_off_q    <= off_d;
            tgt_q       <= tgt_d;
            cnt_q       <= '0;
`ifdef BUZZER_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
          end
        end
        S_LOAD: begin
          cnt_q <= '0;
          if (abort) begin
            state_q        <= S_DONE;
            done_q         <= NUM_REQ'(1) << grant_id_q;
            done_aborted_q <= 1'b1;
            bz_resetn_q    <= 1'b0;
            bz_enable_q    <= 1'b0;
          end else begin
            state_q     <= S_RUN;
            bz_enable_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort wins over a coincident final beep.
          if (abort || (beep_fall && last_beep)) begin
            state_q        <= S_DONE;
            done_q         <= NUM_REQ'(1) << grant_id_q;
            done_aborted_q <= abort;
            bz_resetn_q    <= 1'b0;
            bz_enable_q    <= 1'b0;
          end else if (beep_fall) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q        <= S_IDLE;
          busy_q         <= 1'b0;
          done_aborted_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign done            = done_q;
  assign done_aborted    = done_aborted_q;
  assign busy            = busy_q;
  assign grant_id        = grant_id_q;
  assign bz_resetn       = bz_resetn_q;
  assign bz_enable       = bz_enable_q;
  assign bz_mode         = bz_mode_q;
  assign bz_duration_on  = bz_on_q;
  assign bz_duration_off = bz_off_q;

endmodule

// File: tb/tb_buzzer_request_arbiter.sv
// Scoreboard bench for buzzer_request_arbiter with a simple buzzer core model.
// Grants and completions are checked by a monitor against queued expectations.
module tb_buzzer_request_arbiter;

  localparam int N  = 4;
  localparam int CW = 8;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_mode;
  logic [32*N-1:0] req_on;
  logic [32*N-1:0] req_off;
  logic [CW*N-1:0] req_count;
  logic            abort;
  logic [N-1:0]    done;
  logic            done_aborted;
  logic            busy;
  logic [1:0]      grant_id;
  logic            buzzer_active;
  logic            bz_resetn;
  logic            bz_enable;
  logic [1:0]      bz_mode;
  logic [31:0]     bz_duration_on;
  logic [31:0]     bz_duration_off;

  buzzer_request_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_mode        (req_mode),
    .req_on          (req_on),
    .req_off         (req_off),
    .req_count       (req_count),
    .abort           (abort),
    .done            (done),
    .done_aborted    (done_aborted),
    .busy            (busy),
    .grant_id        (grant_id),
    .buzzer_active   (buzzer_active),
    .bz_resetn       (bz_resetn),
    .bz_enable       (bz_enable),
    .bz_mode         (bz_mode),
    .bz_duration_on  (bz_duration_on),
    .bz_duration_off (bz_duration_off)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Buzzer core model: on-phase first, then alternating on/off.
  logic run;
  int   pc;
  always @(posedge aclk) begin
    if (!bz_resetn || !bz_enable) begin
      run <= 1'b0; buzzer_active <= 1'b0; pc <= 0;
    end else if (!run) begin
      run <= 1'b1; buzzer_active <= 1'b1; pc <= 1;
    end else if (buzzer_active) begin
      if (pc >= int'(bz_duration_on)) begin
        buzzer_active <= 1'b0; pc <= 1;
      end else pc <= pc + 1;
    end else begin
      if (pc >= int'(bz_duration_off)) begin
        buzzer_active <= 1'b1; pc <= 1;
      end else pc <= pc + 1;
    end
  end

  typedef struct {
    int          id;
    logic [1:0]  mode;
    logic [31:0] on;
    logic [31:0] off;
    int          beeps;
    logic        ab;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  bit   auto_drop = 1'b1;
  int   beeps = 0;
  logic mon_prev = 1'b0;
  int   last_done_cyc = -100;
  int   last_turn = 0;
  int   gcount = 0;
  exp_t ge, de;

  always @(negedge aclk) begin
    if (aresetn !== 1'b1) begin
      beeps = 0; mon_prev = 1'b0;
    end else begin
      if (bz_enable && mon_prev && !buzzer_active) beeps++;
      mon_prev = buzzer_active;
      if (req_ready != '0) begin
        gcount++;
        last_turn = cyc - last_done_cyc;
        beeps = 0;
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: req_ready=%b", req_ready);
        end else begin
          ge = gq.pop_front();
          chk("grant_ready", 64'(req_ready), 64'(1 << ge.id));
          chk("grant_id", 64'(grant_id), 64'(ge.id));
          chk("load_mode", 64'(bz_mode), 64'(ge.mode));
          chk("load_on", 64'(bz_duration_on), 64'(ge.on));
          chk("load_off", 64'(bz_duration_off), 64'(ge.off));
          chk("load_resetn", 64'(bz_resetn), 64'd1);
          chk("load_enable", 64'(bz_enable), 64'd0);
          chk("load_busy", 64'(busy), 64'd1);
        end
        if (auto_drop) req_valid = req_valid & ~req_ready;
      end
      if (done != '0) begin
        last_done_cyc = cyc;
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done=%b", done);
        end else begin
          de = dq.pop_front();
          chk("done_vec", 64'(done), 64'(1 << de.id));
          chk("done_aborted", 64'(done_aborted), 64'(de.ab));
          chk("done_enable", 64'(bz_enable), 64'd0);
          chk("done_resetn", 64'(bz_resetn), 64'd0);
          if (de.beeps >= 0) chk("done_beeps", 64'(beeps), 64'(de.beeps));
        end
      end
    end
  end

  logic [1:0]  fm  [N];
  logic [31:0] fon [N];
  logic [31:0] foff[N];

  task automatic setf(int id, logic [1:0] m, logic [31:0] on,
                      logic [31:0] off, logic [CW-1:0] c);
    fm[id] = m; fon[id] = on; foff[id] = off;
    req_mode[2*id +: 2]    = m;
    req_on[32*id +: 32]    = on;
    req_off[32*id +: 32]   = off;
    req_count[CW*id +: CW] = c;
  endtask

  task automatic push_exp(int id, int b, logic ab);
    exp_t e;
    e.id = id; e.mode = fm[id]; e.on = fon[id]; e.off = foff[id];
    e.beeps = b; e.ab = ab;
    gq.push_back(e);
    dq.push_back(e);
  endtask

  task automatic issue(int id, logic [1:0] m, logic [31:0] on,
                       logic [31:0] off, logic [CW-1:0] c, int b);
    setf(id, m, on, off, c);
    push_exp(id, b, 1'b0);
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while ((gq.size() != 0 || dq.size() != 0 || busy) && n < 3000) begin
      @(negedge aclk); n++;
    end
    @(negedge aclk);
    chk({name, "_drain"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_enable(string name);
    int n = 0;
    while (!bz_enable && n < 500) begin
      @(negedge aclk); n++;
    end
    chk({name, "_en"}, 64'(bz_enable), 64'd1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic chk_reset_state(string p);
    chk({p, "_ready"}, 64'(req_ready), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_aborted"}, 64'(done_aborted), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_gid"}, 64'(grant_id), 64'd0);
    chk({p, "_resetn"}, 64'(bz_resetn), 64'd0);
    chk({p, "_enable"}, 64'(bz_enable), 64'd0);
    chk({p, "_mode"}, 64'(bz_mode), 64'd0);
    chk({p, "_on"}, 64'(bz_duration_on), 64'd0);
    chk({p, "_off"}, 64'(bz_duration_off), 64'd0);
  endtask

  int seq[$];
  int n;

  initial begin
    aresetn = 1'b0; req_valid = '0; req_mode = '0; req_on = '0;
    req_off = '0; req_count = '0; abort = 1'b0;

    // Reset values
    repeat (3) @(negedge aclk);
    chk_reset_state("rst");
    aresetn = 1'b1;

    // Abort while idle is ignored
    abort = 1'b1;
    repeat (2) @(negedge aclk);
    chk("idle_abort_busy", 64'(busy), 64'd0);
    chk("idle_abort_done", 64'(done), 64'd0);
    abort = 1'b0;

    // Single request: three beeps
    issue(1, 2'd2, 32'd10, 32'd5, 8'd3, 3);
    wait_drain("single");

    // Zero count gives one beep
    issue(2, 2'd1, 32'd3, 32'd2, 8'd0, 1);
    wait_drain("zero_cnt");

    // Abort two cycles into RUN
    setf(0, 2'd3, 32'd4, 32'd3, 8'd5);
    push_exp(0, -1, 1'b1);
    req_valid[0] = 1'b1;
    wait_enable("abort");
    @(negedge aclk);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    chk("abort_done", 64'(done), 64'b0001);
    chk("abort_flag", 64'(done_aborted), 64'd1);
    chk("abort_resetn", 64'(bz_resetn), 64'd0);
    @(negedge aclk);
    chk("abort_idle", 64'(busy), 64'd0);
    wait_drain("abort");

    // Reset during RUN: no done, then normal re-issue
    issue(3, 2'd1, 32'd6, 32'd4, 8'd4, 4);
    wait_enable("mid_rst");
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    dq.delete();
    @(negedge aclk);
    chk_reset_state("mid_rst");
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    issue(3, 2'd2, 32'd2, 32'd2, 8'd2, 2);
    wait_drain("reissue");

    // Request pending while busy: one idle cycle between grants
    issue(0, 2'd1, 32'd3, 32'd2, 8'd2, 2);
    wait_enable("pend");
    issue(2, 2'd3, 32'd7, 32'd1, 8'd1, 1);
    wait_drain("pend");
    chk("turnaround", 64'(last_turn), 64'd2);

    // Arbitration with 4'b1011 held
    do_reset();
    auto_drop = 1'b0;
    setf(0, 2'd1, 32'd2, 32'd1, 8'd1);
    setf(1, 2'd2, 32'd3, 32'd2, 8'd1);
    setf(3, 2'd3, 32'd1, 32'd1, 8'd1);
`ifdef BUZZER_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 3, 0};
`else
    seq = '{0, 0, 0};
`endif
    foreach (seq[k]) push_exp(seq[k], 1, 1'b0);
    gcount = 0;
    req_valid = 4'b1011;
    n = 0;
    while (gcount < seq.size() && n < 2000) begin
      @(negedge aclk); #1; n++;
    end
    req_valid = '0;
    chk("arb_grants", 64'(gcount), 64'(seq.size()));
    wait_drain("arb");
    auto_drop = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buzzer_request_arbiter.md
BUZZER_REQUEST_ARBITER -- requirements
Module: buzzer_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one buzzer core.
REQ-002 Parameter CNT_W, default 8, width of the per-request beep count.
REQ-003 aclk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low; clock aclk.
REQ-005 req_valid  input  NUM_REQ  per-requester request; held high with stable fields until accepted.
REQ-006 req_ready  output  NUM_REQ  one-cycle accept strobe for the granted requester.
REQ-007 req_mode  input  2*NUM_REQ  buzzer mode per requester, slice i = [2i+1:2i].
REQ-008 req_on, req_off  input  32*NUM_REQ each  on/off durations in aclk cycles per requester.
REQ-009 req_count  input  CNT_W*NUM_REQ  beeps requested; 0 is treated as 1.
REQ-010 abort  input  1  terminates the active request.
REQ-011 done  output  NUM_REQ  one-cycle completion strobe to the owning requester.
REQ-012 done_aborted  output  1  qualifies done: 1 = terminated by abort.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  $clog2(NUM_REQ)  index of current/last owner.
REQ-015 buzzer_active  input  1  on-phase indicator from buzzer core.
REQ-016 bz_resetn, bz_enable  output  1 each  buzzer core control.
REQ-017 bz_mode  output  2; bz_duration_on, bz_duration_off  output  32 each; latched parameters to buzzer core.

Function
REQ-018 States: IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-019 IDLE: bz_resetn=0, bz_enable=0; when any req_valid is high, select winner, latch its mode/on/off/count, set grant_id, go to LOAD.
REQ-020 req_ready[winner] is high for exactly the LOAD cycle; no other req_ready bit is ever high in that cycle.
REQ-021 LOAD (one cycle): bz_resetn=1, bz_enable=0, bz_mode/bz_duration_* drive latched values; beep counter cleared; next RUN.
REQ-022 RUN: bz_enable=1; a beep completes on a falling edge of buzzer_active (registered previous=1, current=0).
REQ-023 Beep counter is CNT_W bits; on the falling edge that makes completed beeps equal the target, go to DONE.
REQ-024 abort in LOAD or RUN goes to DONE next cycle with done_aborted=1; abort in IDLE or DONE is ignored.
REQ-025 abort and final falling edge in the same cycle: DONE with done_aborted=1.
REQ-026 DONE (one cycle): bz_enable=0, bz_resetn=0, done[grant_id]=1, done_aborted valid; next IDLE.
REQ-027 Requests arriving while busy are held pending; none is dropped or accepted until IDLE.
REQ-028 Minimum request-to-request turnaround: DONE -> IDLE -> LOAD, one idle cycle between consecutive grants.

Reset
REQ-029 On aresetn=0: state IDLE, req_ready=0, done=0, done_aborted=0, busy=0, grant_id=0, bz_resetn=0, bz_enable=0, bz_mode=0, bz_duration_*=0, counters 0, round-robin pointer 0.
REQ-030 Reset mid-operation abandons the request without done; requester must re-issue.

Configuration
REQ-031 Macro BUZZER_ARB_ROUND_ROBIN_EN defined: winner is the first valid index at or after (last grant + 1) modulo NUM_REQ; pointer updates on each grant.
REQ-032 Macro undefined: fixed priority, lowest valid index wins; no pointer logic compiled.

Verification
REQ-033 Single request: req_valid[1], count=3, on=10, off=5, core model -> req_ready[1] one cycle, bz_enable high until third falling edge, done[1]=1, done_aborted=0.
REQ-034 count=0 -> exactly one beep then done.
REQ-035 Simultaneous req_valid=4'b1011 repeatedly: with macro grants 0,1,3,0; without macro grants 0,0,0.
REQ-036 abort two cycles into RUN -> DONE next cycle, done_aborted=1, bz_resetn=0 then IDLE.
REQ-037 aresetn low during RUN -> all outputs to reset values next cycle, no done; next request granted normally.
REQ-038 Request raised while busy -> accepted exactly one cycle after previous DONE's IDLE cycle, fields latched intact.
